// File: rtl/mult_pkg.sv
// Shared types and default sizing for the multiplier feeder.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_MULT_CYCLES = 8;

endpackage

// File: rtl/mult_feeder.sv
// Feeds operand pairs to a sequential multiplier, waits out its latency and holds the product.
// Optional feature: define MULT_FEEDER_ZERO_BYPASS_EN to short-circuit pairs with a zero operand.
module mult_feeder
  import mult_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               mult_enable,
  output logic [WIDTH-1:0]   mult_a,
  output logic [WIDTH-1:0]   mult_b,
  input  logic [2*WIDTH-1:0] mult_c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_c,
  output logic               busy
);

  localparam int CNT_W = (MULT_CYCLES > 0) ? $clog2(MULT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_CYCLES);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [WIDTH-1:0]   a_reg, a_next;
  logic [WIDTH-1:0]   b_reg, b_next;
  logic [2*WIDTH-1:0] c_reg, c_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      c_reg     <= c_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    c_next     = c_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          a_next   = in_a;
          b_next   = in_b;
          cnt_next = '0;
`ifdef MULT_FEEDER_ZERO_BYPASS_EN
          // A zero operand makes the product known; skip the multiplier entirely.
          if (in_a == '0 || in_b == '0) begin
            c_next     = '0;
            state_next = HOLD;
          end else begin
            state_next = RUN;
          end
`else
          state_next = RUN;
`endif
        end
      end
      RUN: begin
        // Enable stays high for counts 0..MULT_CYCLES, i.e. MULT_CYCLES+1 cycles.
        if (cnt_reg == CNT_LAST) begin
          c_next     = mult_c;
          state_next = HOLD;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready    = (state_reg == IDLE);
  assign mult_enable = (state_reg == RUN);
  assign out_valid   = (state_reg == HOLD);
  assign busy        = (state_reg != IDLE);
  assign mult_a      = a_reg;
  assign mult_b      = b_reg;
  assign out_c       = c_reg;

endmodule

// File: tb/tb_mult_feeder.sv
// Directed and randomized checks of mult_feeder against a plain product model.
module tb_mult_feeder;

  localparam int W  = 8;
  localparam int MC = 8;
`ifdef MULT_FEEDER_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_a = '0;
  logic [W-1:0]   in_b = '0;
  logic           mult_enable;
  logic [W-1:0]   mult_a;
  logic [W-1:0]   mult_b;
  logic [2*W-1:0] mult_c;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] out_c;
  logic           busy;

  int checks = 0;
  int errors = 0;

  mult_feeder #(.WIDTH(W), .MULT_CYCLES(MC)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mult_enable(mult_enable), .mult_a(mult_a), .mult_b(mult_b), .mult_c(mult_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .busy(busy)
  );

  always #5 clk = ~clk;

  // Sequential multiplier model: product appears after MC enabled clocks, 0 while disabled.
  int m_cnt = 0;
  always @(posedge clk) m_cnt <= mult_enable ? m_cnt + 1 : 0;
  assign mult_c = (mult_enable && m_cnt >= MC) ? ({8'd0, mult_a} * {8'd0, mult_b}) : '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One full operation; drive and sample on negedges.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int stall,
                        input bit keep, input logic [W-1:0] na, input logic [W-1:0] nb);
    int lat, en_cnt, t;
    logic [31:0] exp_c;
    bit bp;
    exp_c = a * b;
    bp = BYPASS && (a == 0 || b == 0);
    in_valid = 1'b1; in_a = a; in_b = b;
    t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    check("accept_ready", {31'd0, in_ready}, 1);
    @(negedge clk);
    if (keep) begin in_a = na; in_b = nb; end else in_valid = 1'b0;
    lat = 1; en_cnt = 0;
    while (!out_valid && lat < 100) begin
      if (mult_enable) en_cnt++;
      check("run_opa_stable", {24'd0, mult_a}, {24'd0, a});
      check("run_opb_stable", {24'd0, mult_b}, {24'd0, b});
      check("run_in_ready", {31'd0, in_ready}, 0);
      @(negedge clk); lat++;
    end
    check("latency", lat, bp ? 1 : MC + 2);
    check("enable_cycles", en_cnt, bp ? 0 : MC + 1);
    check("out_c", {16'd0, out_c}, exp_c);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, out_valid}, 1);
      check("hold_out_c", {16'd0, out_c}, exp_c);
      check("hold_in_ready", {31'd0, in_ready}, 0);
      check("hold_enable", {31'd0, mult_enable}, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_after_hs", {31'd0, in_ready}, 1);
    check("idle_valid", {31'd0, out_valid}, 0);
    $display("op a=%0d b=%0d stall=%0d -> out_c=%0d exp=%0d lat=%0d", a, b, stall, out_c, exp_c, lat);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_enable", {31'd0, mult_enable}, 0);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_mult_a", {24'd0, mult_a}, 0);
    check("rst_out_c", {16'd0, out_c}, 0);

    run_op(8'd200, 8'd100, 0, 1'b0, 8'd0, 8'd0);
    run_op(8'd255, 8'd255, 0, 1'b0, 8'd0, 8'd0);
    run_op(8'd17, 8'd9, 20, 1'b0, 8'd0, 8'd0);

    // Reset in the 4th RUN cycle aborts the operation
    in_valid = 1'b1; in_a = 8'd50; in_b = 8'd60;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_enable", {31'd0, mult_enable}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_out_valid", {31'd0, out_valid}, 0);
    check("abort_mult_a", {24'd0, mult_a}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("abort_no_result", {31'd0, out_valid}, 0);
    end
    $display("abort a=50 b=60 -> no result");
    run_op(8'd3, 8'd7, 0, 1'b0, 8'd0, 8'd0);

    // Zero operand
    run_op(8'd0, 8'd77, 2, 1'b0, 8'd0, 8'd0);

    // Back-to-back with in_valid held high
    run_op(8'd12, 8'd12, 0, 1'b1, 8'd13, 8'd13);
    run_op(8'd13, 8'd13, 0, 1'b0, 8'd0, 8'd0);

    // Randomized operands and stalls
    for (int k = 0; k < 8; k++) begin
      ra = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(ra, rb, $urandom_range(0, 3), 1'b0, 8'd0, 8'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_feeder.md
MULT_FEEDER -- requirements
Module: mult_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits.
REQ-002 SHALL have parameter MULT_CYCLES, default 8, number of enabled clocks the downstream sequential multiplier needs before its product is valid.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  upstream operand pair valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-007 SHALL have port in_a  input  WIDTH  multiplicand.
REQ-008 SHALL have port in_b  input  WIDTH  multiplier.
REQ-009 SHALL have port mult_enable  output  1  enable to the sequential multiplier.
REQ-010 SHALL have port mult_a  output  WIDTH  operand A to the multiplier.
REQ-011 SHALL have port mult_b  output  WIDTH  operand B to the multiplier.
REQ-012 SHALL have port mult_c  input  2*WIDTH  product from the multiplier.
REQ-013 SHALL have port out_valid  output  1  result valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts result.
REQ-015 SHALL have port out_c  output  2*WIDTH  captured product.
REQ-016 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, HOLD; in_ready = 1 only in IDLE.
REQ-018 IDLE: on in_valid & in_ready, SHALL latch in_a/in_b into mult_a/mult_b, clear counter, go RUN.
REQ-019 RUN: mult_enable = 1 for exactly MULT_CYCLES+1 consecutive cycles; mult_a/mult_b stable throughout.
REQ-020 On the rising edge ending the last RUN cycle, SHALL capture mult_c into out_c, go HOLD.
REQ-021 HOLD: out_valid = 1, out_c stable; on out_ready go IDLE; out_valid stays high while out_ready = 0, indefinitely.
REQ-022 Latency SHALL be MULT_CYCLES+2 cycles from input-handshake edge to first cycle with out_valid = 1; throughput one result per MULT_CYCLES+3 cycles when out_ready is held high.
REQ-023 mult_enable SHALL be 0 in IDLE and HOLD; mult_a/mult_b keep last values outside RUN.
REQ-024 Counter width SHALL be $clog2(MULT_CYCLES+1); counter SHALL not wrap within one operation.
REQ-025 in_valid during RUN/HOLD SHALL be ignored; the upstream pair is held by the upstream source until in_ready.
REQ-026 out_c SHALL be taken verbatim from mult_c, no truncation or extension.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, counter 0, mult_enable 0, mult_a/mult_b/out_c 0, out_valid 0, busy 0, in_ready 1 after release.
REQ-028 Reset during RUN SHALL abort the operation with no result produced; first operation after release behaves per REQ-022.

Configuration
REQ-029 Macro MULT_FEEDER_ZERO_BYPASS_EN: when defined, an accepted pair with in_a = 0 or in_b = 0 SHALL skip RUN (mult_enable never asserted), set out_c = 0, enter HOLD the next cycle (latency 1).
REQ-030 Without MULT_FEEDER_ZERO_BYPASS_EN, zero operands SHALL take the normal RUN path per REQ-019..REQ-022.

Structure
REQ-031 Shared package mult_pkg SHALL hold the FSM state enum type and the default constants for WIDTH and MULT_CYCLES.
REQ-032 No sub-module; FSM and counter SHALL be a single module.

Verification
Bench drives mult_c from a behavioural multiplier model that produces A*B after MULT_CYCLES enabled clocks and 0 while enable is low.
REQ-033 Operands 200, 100, out_ready = 1 -> mult_enable high 9 cycles, out_c = 20000 (0x4E20), out_valid 10 cycles after accept.
REQ-034 Operands 255, 255 -> out_c = 65025 (0xFE01).
REQ-035 out_ready held 0 for 20 cycles after out_valid -> out_valid and out_c stay constant, in_ready stays 0; out_ready = 1 -> IDLE next cycle.
REQ-036 rst_n pulsed low on the 4th RUN cycle -> mult_enable 0 immediately, no out_valid; next pair 3, 7 -> out_c = 21.
REQ-037 Operands 0, 77: with MULT_FEEDER_ZERO_BYPASS_EN -> mult_enable never high, out_valid 1 cycle after accept, out_c = 0; without it -> normal latency, out_c = 0.
REQ-038 Back-to-back pairs (12,12), (13,13) with in_valid held high -> second accepted only after first result handshake; out_c = 144 then 169.
